// File: rtl/uart_rx_word_if.sv
// Word stream from the UART receiver to its consumer: valid/ready handshake
// carrying one 64-bit packed word per transfer.
interface uart_rx_word_if;
  logic [63:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, word_valid, input word_ready);
  modport slave  (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/uart_rx_word.sv
// UART 8N1 receiver: synchronises rx, validates framing, emits bytes and packs
// each run of 8 bytes into a 64-bit word handed off over valid/ready.

module uart_rx_word_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] nxt
);
  logic [7:0] lane_q;

  always_ff @(posedge clk or posedge rst)
    if (rst)     lane_q <= '0;
    else if (we) lane_q <= d;

  // Bypass so the word completing this cycle already contains the 8th byte.
  assign nxt = we ? d : lane_q;
endmodule

module uart_rx_word #(
  parameter int clock_speed = 100_000_000,
  parameter int baud_rate   = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  endianness,
  uart_rx_word_if.master        word,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  output logic [2:0]            bytecount,
  output logic                  framing_error,
  output logic                  overrun
);
  localparam int BIT_CLKS  = clock_speed / baud_rate;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS);
  localparam int NUM_LANES = 8;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tick_half, tick_bit;
  logic            cnt_clr, shift_en, byte_ok, frame_bad;
  logic            endian_q, endian_sel;
  logic [2:0]      lane_idx;
  logic            word_done;
  logic [NUM_LANES-1:0][7:0] lane_nxt;
  logic [63:0]     word_q;
  logic            wvalid_q;

  // Two-flop synchroniser, idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) {rxs, rx_meta} <= 2'b11;
    else     {rxs, rx_meta} <= {rx_meta, rx};

  assign tick_half = (cnt == HALF_LAST);
  assign tick_bit  = (cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs) state_d = START;
      START:   if (tick_half) state_d = rxs ? IDLE : DATA;
      DATA:    if (tick_bit && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (tick_bit) state_d = rxs ? IDLE : BRK;
      BRK:     if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b1;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      START: cnt_clr = tick_half;
      DATA: begin
        cnt_clr  = tick_bit;
        shift_en = tick_bit;
      end
      STOP: begin
        cnt_clr   = tick_bit;
        byte_ok   = tick_bit && rxs;
        frame_bad = tick_bit && !rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rxs, shreg[7:1]};
      end else if (state_q != DATA) begin
        bit_idx <= '0;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_valid    <= byte_ok;
      framing_error <= frame_bad;
      if (byte_ok) byte_data <= shreg;
    end

  // Endianness is live for the first byte of a word, then frozen until wrap.
  assign endian_sel = (bytecount == 3'd0) ? endianness : endian_q;
  assign lane_idx   = endian_sel ? (3'd7 - bytecount) : bytecount;
  assign word_done  = byte_ok && (bytecount == 3'd7);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bytecount <= '0;
      endian_q  <= 1'b0;
    end else if (byte_ok) begin
      bytecount <= bytecount + 1'b1;
      if (bytecount == 3'd0) endian_q <= endianness;
    end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    uart_rx_word_lane u_lane (
      .clk (clk),
      .rst (rst),
      .we  (byte_ok && (lane_idx == 3'(n))),
      .d   (shreg),
      .nxt (lane_nxt[n])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_q   <= '0;
      wvalid_q <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done && (!wvalid_q || word.word_ready)) begin
        word_q   <= lane_nxt;
        wvalid_q <= 1'b1;
      end else if (word_done) begin
        overrun <= 1'b1;
      end else if (wvalid_q && word.word_ready) begin
        wvalid_q <= 1'b0;
      end
    end

  assign word.word_data  = word_q;
  assign word.word_valid = wvalid_q;
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit: framing, packing,
// endianness, glitch and break handling, overrun and async reset.
module tb_uart_rx_word;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       endianness = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [2:0] bytecount;
  logic       framing_error;
  logic       overrun;

  uart_rx_word_if wif();

  uart_rx_word #(.clock_speed(16), .baud_rate(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .endianness    (endianness),
    .word          (wif),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .bytecount     (bytecount),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          nbyte = 0, nfe = 0, novr = 0, nword = 0;
  logic [7:0]  last_byte = '0;
  logic [63:0] last_word = '0;
  logic        wv_q = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin
      nbyte++;
      last_byte = byte_data;
    end
    if (framing_error) nfe++;
    if (overrun) novr++;
    if (wif.word_valid && !wv_q) begin
      nword++;
      last_word = wif.word_data;
    end
    wv_q = wif.word_valid;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    rx = stop;
    wait_clks(BIT);
    if (stop) begin
      rx = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
  endtask

  int b0, f0, o0, w0;

  initial begin
    wif.word_ready = 1'b1;
    wait_clks(3);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_word_data", wif.word_data, 0);
    chk("rst_word_valid", wif.word_valid, 0);
    chk("rst_bytecount", bytecount, 0);
    chk("rst_framing", framing_error, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    wait_clks(4);

    // Single byte
    b0 = nbyte; f0 = nfe;
    send_byte(8'hA5, 1'b1);
    wait_clks(8);
    chk("a5_count", nbyte - b0, 1);
    chk("a5_data", last_byte, 8'hA5);
    chk("a5_bytecount", bytecount, 1);
    chk("a5_no_fe", nfe - f0, 0);

    // Little-endian word, consumer always ready
    do_reset();
    w0 = nword;
    endianness = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    wait_clks(4);
    chk("le_words", nword - w0, 1);
    chk("le_data", last_word, 64'h0807060504030201);
    chk("le_valid_cleared", wif.word_valid, 0);
    chk("le_bytecount", bytecount, 0);

    // Big-endian word; endianness flipped mid-word must be ignored
    w0 = nword;
    endianness = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 3) endianness = 1'b0;
    end
    wait_clks(4);
    chk("be_words", nword - w0, 1);
    chk("be_data", last_word, 64'h0102030405060708);

    // Short low glitch while idle is rejected
    b0 = nbyte;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(40);
    chk("glitch_no_byte", nbyte - b0, 0);
    send_byte(8'h3C, 1'b1);
    wait_clks(4);
    chk("post_glitch_count", nbyte - b0, 1);
    chk("post_glitch_data", last_byte, 8'h3C);

    // Bad stop bit followed by a long break
    b0 = nbyte; f0 = nfe;
    send_byte(8'h55, 1'b0);
    wait_clks(100);
    rx = 1'b1;
    wait_clks(8);
    chk("brk_fe_once", nfe - f0, 1);
    chk("brk_no_byte", nbyte - b0, 0);
    chk("brk_bytecount", bytecount, 1);
    send_byte(8'h99, 1'b1);
    wait_clks(4);
    chk("post_brk_data", last_byte, 8'h99);
    chk("post_brk_bytecount", bytecount, 2);

    // Consumer stalled: second word dropped with one overrun
    do_reset();
    w0 = nword; o0 = novr;
    endianness = 1'b0;
    wif.word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    wait_clks(4);
    chk("ovr_pulses", novr - o0, 1);
    chk("ovr_words", nword - w0, 1);
    chk("ovr_valid_held", wif.word_valid, 1);
    chk("ovr_data_held", wif.word_data, 64'h0706050403020100);
    wif.word_ready = 1'b1;
    wait_clks(1);
    chk("ready_clears_valid", wif.word_valid, 0);

    // Async reset in the middle of the 3rd byte
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(3 * BIT);
    #2 rst = 1'b1;
    #1;
    chk("arst_byte_data", byte_data, 0);
    chk("arst_byte_valid", byte_valid, 0);
    chk("arst_word_data", wif.word_data, 0);
    chk("arst_word_valid", wif.word_valid, 0);
    chk("arst_bytecount", bytecount, 0);
    chk("arst_framing", framing_error, 0);
    chk("arst_overrun", overrun, 0);
    wait_clks(2);
    rst = 1'b0;
    rx = 1'b1;
    wait_clks(3 * BIT);
    w0 = nword;
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), 1'b1);
    wait_clks(4);
    chk("arst_words", nword - w0, 1);
    chk("arst_word", last_word, 64'h8877665544332211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
